// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {FETCH, SKID, KILL} fetch_state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_BR, SEL_JMP, SEL_EXC} redir_sel_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_0008;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory handshake plus IF/ID boundary signals of the fetch sequencer.
interface fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4,
    input  imem_ack, imem_rdata, stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4,
    output imem_ack, imem_rdata, stall
  );

endinterface

// File: rtl/fetch_redirect_sel.sv
// Priority mux for next-PC redirects (exc > jmp > br_taken).
// The exception leg exists only when FETCH_EXC_EN is defined.
module fetch_redirect_sel
  import fetch_pkg::*;
`ifdef FETCH_EXC_EN
#(
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
)
`endif
(
  input  logic        br_taken,
  input  logic [31:0] bpc,
  input  logic        jmp,
  input  logic [31:0] jpc,
`ifdef FETCH_EXC_EN
  input  logic        exc,
`endif
  output logic        redirect,
  output logic [31:0] target
);

  redir_sel_e w_sel;

  // Lowest priority first so later assignments win.
  always_comb begin
    w_sel = SEL_NONE;
    if (br_taken) w_sel = SEL_BR;
    if (jmp)      w_sel = SEL_JMP;
`ifdef FETCH_EXC_EN
    if (exc)      w_sel = SEL_EXC;
`endif
  end

  always_comb begin
    target = '0;
    case (w_sel)
`ifdef FETCH_EXC_EN
      SEL_EXC: target = EXC_VEC;
`endif
      SEL_JMP: target = jpc;
      SEL_BR:  target = bpc;
      default: target = '0;
    endcase
  end

  assign redirect = (w_sel != SEL_NONE);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues handshaked imem fetches, skids one
// instruction under ID stall and discards fetches orphaned by a redirect.
// Optional exception redirect is enabled by defining FETCH_EXC_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef FETCH_EXC_EN
  , parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
`endif
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         br_taken,
  input  logic [31:0]  bpc,
  input  logic         jmp,
  input  logic [31:0]  jpc,
`ifdef FETCH_EXC_EN
  input  logic         exc,
`endif
  fetch_ctrl_if.master bus
);

  fetch_state_e r_state, w_state_n;
  logic [31:0]  r_pc, w_pc_n;
  logic [31:0]  r_kill_addr, w_kill_addr_n;
  logic [31:0]  r_skid_inst, w_skid_inst_n;
  logic [31:0]  r_skid_pc, w_skid_pc_n;
  logic         r_if_valid, w_if_valid_n;
  logic [31:0]  r_if_inst, w_if_inst_n;
  logic [31:0]  r_if_pc, w_if_pc_n;
  logic [31:0]  r_if_pc4, w_if_pc4_n;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_req;
  logic         w_ack;

  fetch_redirect_sel
`ifdef FETCH_EXC_EN
    #(.EXC_VEC(EXC_VEC))
`endif
    u_sel (
      .br_taken (br_taken),
      .bpc      (bpc),
      .jmp      (jmp),
      .jpc      (jpc),
`ifdef FETCH_EXC_EN
      .exc      (exc),
`endif
      .redirect (w_redirect),
      .target   (w_target)
    );

  assign w_req         = !clr && (r_state == FETCH || r_state == KILL);
  assign w_ack         = w_req && bus.imem_ack;
  assign bus.imem_req  = w_req;
  assign bus.imem_addr = clr ? RESET_PC : ((r_state == KILL) ? r_kill_addr : r_pc);
  assign bus.if_valid  = r_if_valid;
  assign bus.if_inst   = r_if_inst;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_pc4    = r_if_pc4;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_kill_addr <= '0;
      r_skid_inst <= '0;
      r_skid_pc   <= '0;
      r_if_valid  <= 1'b0;
      r_if_inst   <= '0;
      r_if_pc     <= '0;
      r_if_pc4    <= '0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_kill_addr <= w_kill_addr_n;
      r_skid_inst <= w_skid_inst_n;
      r_skid_pc   <= w_skid_pc_n;
      r_if_valid  <= w_if_valid_n;
      r_if_inst   <= w_if_inst_n;
      r_if_pc     <= w_if_pc_n;
      r_if_pc4    <= w_if_pc4_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_kill_addr_n = r_kill_addr;
    w_skid_inst_n = r_skid_inst;
    w_skid_pc_n   = r_skid_pc;
    w_if_valid_n  = r_if_valid;
    w_if_inst_n   = r_if_inst;
    w_if_pc_n     = r_if_pc;
    w_if_pc4_n    = r_if_pc4;

    if (w_redirect) begin
      w_pc_n        = w_target;
      w_if_valid_n  = 1'b0;
      w_skid_inst_n = '0;
      w_skid_pc_n   = '0;
      case (r_state)
        FETCH: begin
          // An unacked request must still complete; its data is then discarded.
          if (!w_ack) begin
            w_kill_addr_n = r_pc;
            w_state_n     = KILL;
          end
        end
        SKID:    w_state_n = FETCH;
        default: w_state_n = KILL;
      endcase
    end else begin
      case (r_state)
        FETCH: begin
          if (w_ack) begin
            if (!r_if_valid || !bus.stall) begin
              w_if_valid_n = 1'b1;
              w_if_inst_n  = bus.imem_rdata;
              w_if_pc_n    = r_pc;
              w_if_pc4_n   = pc_inc(r_pc);
            end else begin
              w_skid_inst_n = bus.imem_rdata;
              w_skid_pc_n   = r_pc;
              w_state_n     = SKID;
            end
            w_pc_n = pc_inc(r_pc);
          end else if (!bus.stall) begin
            w_if_valid_n = 1'b0;
          end
        end
        SKID: begin
          if (!bus.stall) begin
            w_if_valid_n = 1'b1;
            w_if_inst_n  = r_skid_inst;
            w_if_pc_n    = r_skid_pc;
            w_if_pc4_n   = pc_inc(r_skid_pc);
            w_state_n    = FETCH;
          end
        end
        default: begin
          if (w_ack) w_state_n = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        clr;
  logic        br_taken;
  logic [31:0] bpc;
  logic        jmp;
  logic [31:0] jpc;
`ifdef FETCH_EXC_EN
  logic        exc;
`endif

  fetch_ctrl_if bus ();

`ifdef FETCH_EXC_EN
  fetch_ctrl #(.RESET_PC(RST_PC), .EXC_VEC(EXC_PC)) dut (
    .clk(clk), .clr(clr), .br_taken(br_taken), .bpc(bpc),
    .jmp(jmp), .jpc(jpc), .exc(exc), .bus(bus)
  );
`else
  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .clr(clr), .br_taken(br_taken), .bpc(bpc),
    .jmp(jmp), .jpc(jpc), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_inst, m_ipc, m_ipc4;
  logic        m_discard;
  logic [31:0] m_kill;
  ent_t        m_skid[$];

  // Memory responder state
  bit          mem_busy;
  int          mem_left;
  int          mem_minw, mem_maxw;

  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic m_req();
    return !clr && (m_skid.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    if (clr) return RST_PC;
    return m_discard ? m_kill : m_pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic ack, input logic [31:0] rd);
    logic        redir;
    logic [31:0] tgt;
    ent_t        e;
    redir = jmp || br_taken;
    tgt   = jmp ? jpc : bpc;
`ifdef FETCH_EXC_EN
    if (exc) begin
      redir = 1'b1;
      tgt   = EXC_PC;
    end
`endif
    if (clr) begin
      m_pc = RST_PC; m_valid = 1'b0; m_inst = '0; m_ipc = '0; m_ipc4 = '0;
      m_skid.delete(); m_discard = 1'b0; m_kill = '0;
    end else if (redir) begin
      if (!m_discard && m_skid.size() == 0 && !ack) begin
        m_discard = 1'b1;
        m_kill    = m_pc;
      end
      m_skid.delete();
      m_pc    = tgt;
      m_valid = 1'b0;
    end else if (m_discard) begin
      if (ack) m_discard = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (!bus.stall) begin
        e = m_skid.pop_front();
        m_valid = 1'b1; m_inst = e.inst; m_ipc = e.pc; m_ipc4 = e.pc + 32'd4;
      end
    end else if (ack) begin
      if (!m_valid || !bus.stall) begin
        m_valid = 1'b1; m_inst = rd; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
      end else begin
        m_skid.push_back('{inst: rd, pc: m_pc});
      end
      m_pc = m_pc + 32'd4;
    end else if (!bus.stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("imem_req",  {31'b0, bus.imem_req}, {31'b0, m_req()});
    chk("imem_addr", bus.imem_addr, m_addr());
    chk("if_valid",  {31'b0, bus.if_valid}, {31'b0, m_valid});
    chk("if_inst",   bus.if_inst, m_inst);
    chk("if_pc",     bus.if_pc,   m_ipc);
    chk("if_pc4",    bus.if_pc4,  m_ipc4);
  endtask

  // One clock: memory decides ack for the current request, model advances,
  // then outputs are compared on the falling edge.
  task automatic cycle();
    logic        ack;
    logic [31:0] rd;
    ack = 1'b0;
    rd  = $urandom;
    if (clr) begin
      mem_busy = 1'b0;
    end else if (m_req()) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = $urandom_range(mem_maxw, mem_minw);
      end
      if (mem_left == 0) begin
        ack      = 1'b1;
        mem_busy = 1'b0;
        rd       = memf(m_addr());
      end else begin
        mem_left--;
      end
    end
    bus.imem_ack   = ack;
    bus.imem_rdata = rd;
    model_step(ack, rd);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_mem(input int minw, input int maxw);
    mem_minw = minw;
    mem_maxw = maxw;
  endtask

  initial begin
    clr = 1'b1; bus.stall = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    bpc = '0; jpc = '0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
`ifdef FETCH_EXC_EN
    exc = 1'b0;
`endif
    mem_busy = 1'b0; mem_left = 0;
    set_mem(0, 0);

    // Reset
    repeat (2) cycle();
    clr = 1'b0;

    // Zero-wait streaming
    repeat (8) cycle();

    // Two wait states per request
    set_mem(2, 2);
    repeat (12) cycle();

    // Stall with full output regs while acks arrive
    set_mem(0, 0);
    repeat (2) cycle();
    bus.stall = 1'b1;
    repeat (3) cycle();
    bus.stall = 1'b0;
    repeat (4) cycle();

    // Jump while a fetch is pending
    set_mem(3, 3);
    cycle();
    jmp = 1'b1; jpc = 32'h100;
    cycle();
    jmp = 1'b0;
    repeat (10) cycle();

    // All redirect sources at once
    set_mem(0, 0);
    br_taken = 1'b1; bpc = 32'h40; jmp = 1'b1; jpc = 32'h80;
`ifdef FETCH_EXC_EN
    exc = 1'b1;
`endif
    cycle();
    br_taken = 1'b0; jmp = 1'b0;
`ifdef FETCH_EXC_EN
    exc = 1'b0;
`endif
    repeat (4) cycle();

    // PC wrap at the top of the address space
    jmp = 1'b1; jpc = 32'hFFFF_FFF8;
    cycle();
    jmp = 1'b0;
    repeat (5) cycle();

    // Reset asserted while a fetch waits
    set_mem(3, 3);
    cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (6) cycle();

    // Random traffic
    set_mem(0, 3);
    for (int i = 0; i < 800; i++) begin
      bus.stall = ($urandom_range(3, 0) == 0);
      br_taken  = ($urandom_range(15, 0) == 0);
      jmp       = ($urandom_range(19, 0) == 0);
      bpc       = {$urandom_range(255, 0), 2'b00};
      jpc       = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF4 : {$urandom_range(255, 0), 2'b00};
`ifdef FETCH_EXC_EN
      exc       = ($urandom_range(39, 0) == 0);
`endif
      clr       = ($urandom_range(99, 0) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
